nor_target: RTL
===============

NOR_TARGET -- requirements
Module: nor_target

Interface
REQ-001 Parameter ADDRBITS, default 26, NOR address width.
REQ-002 Parameter DATABITS, default 16, NOR data width.
REQ-003 Parameter BUSY_CYCLES, default 5, RY/BY low time after write commit, in clocks; 8-bit.
REQ-004 clk_i  in  1  single block clock.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 nor_ce_i, nor_we_i, nor_oe_i  in  1 each  NOR strobes, active-low, asynchronous to clk_i.
REQ-007 nor_addr_i  in  ADDRBITS  NOR address.
REQ-008 nor_data_i  in  DATABITS  NOR write data from initiator.
REQ-009 nor_data_o  out  DATABITS  NOR read data to initiator.
REQ-010 nor_data_oe  out  1  1 = block drives NOR data bus.
REQ-011 nor_ry_o  out  1  RY/BY, 1 = ready, 0 = busy.
REQ-012 mem_req_o  out  1  backing-store request, held until mem_ack_i.
REQ-013 mem_we_o  out  1  1 = write request.
REQ-014 mem_addr_o  out  ADDRBITS  request address; mem_data_o  out  DATABITS  write data.
REQ-015 mem_data_i  in  DATABITS  read data, valid with mem_ack_i; mem_ack_i  in  1  one-cycle completion.
REQ-016 proto_err_o  out  1  one-cycle pulse on illegal strobe combination.

Function
REQ-017 ce/we/oe shall pass through 2-flop synchronizers (reset value 1); all decoding uses synchronized values; pin-to-decode latency 2 clocks.
REQ-018 States: IDLE, RD_REQ, RD_DRIVE, WR_REQ, WR_BUSY, RELEASE.
REQ-019 IDLE: ce=0, oe=0, we=1 -> latch nor_addr_i, go RD_REQ; ce=0, we=0, oe=1 -> latch nor_addr_i and nor_data_i, go WR_REQ.
REQ-020 IDLE with ce=0, we=0, oe=0 -> pulse proto_err_o, go RELEASE, no memory access.
REQ-021 RD_REQ: mem_req_o=1, mem_we_o=0 until mem_ack_i; on ack register mem_data_i into nor_data_o, go RD_DRIVE.
REQ-022 RD_DRIVE: nor_data_oe=1; when synchronized ce or oe reads 1, nor_data_oe=0 next clock, go IDLE.
REQ-023 WR_REQ: nor_ry_o=0 from entry; mem_req_o=1, mem_we_o=1 until mem_ack_i, then load busy counter, go WR_BUSY.
REQ-024 WR_BUSY: nor_ry_o=0; counter counts up from 0; at count == BUSY_CYCLES go RELEASE; BUSY_CYCLES=0 leaves WR_BUSY after one clock.
REQ-025 RELEASE: nor_ry_o=1; go IDLE once synchronized ce=1.
REQ-026 nor_data_oe shall be 1 only in RD_DRIVE; never 1 while synchronized we=0.
REQ-027 Initiator deasserting ce during RD_REQ or WR_REQ shall not abort the memory request; the FSM completes the request, skips RD_DRIVE (read), then returns via RELEASE.
REQ-028 Write while nor_ry_o=0 (initiator error) is ignored until RELEASE->IDLE; no second memory request.
REQ-029 mem_addr_o/mem_data_o stable while mem_req_o=1; mem_req_o falls the clock after mem_ack_i.
REQ-030 mem_ack_i outside RD_REQ/WR_REQ ignored.

Reset
REQ-031 rst_ni low: state IDLE, nor_data_oe=0, nor_ry_o=1, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, nor_data_o=0, proto_err_o=0, counter=0, synchronizers=1.
REQ-032 Reset mid-transaction aborts immediately; outstanding mem_ack_i after reset ignored.

Structure
REQ-033 State encoding and default BUSY_CYCLES shall live in shared package nor_pkg, also used by the NOR bus initiator.
REQ-034 Strobe synchronizer shall be sub-module nor_sync2 (3 bits, reset-to-1).

Verification
REQ-035 Read: addr 0x0000123, oe/ce low, mem_ack after 3 clocks with 0xBEEF -> nor_data_o=0xBEEF, nor_data_oe=1 until oe high +2..3 clocks.
REQ-036 Write: addr 0x3FFFFFF, data 0xA5A5 -> one mem write 0xA5A5@0x3FFFFFF, nor_ry_o low from WR_REQ through BUSY_CYCLES=5 clocks after ack.
REQ-037 we=oe=ce=0 -> proto_err_o single pulse, mem_req_o stays 0, nor_data_oe stays 0.
REQ-038 ce released during RD_REQ -> read completes, nor_data_oe never asserted, return to IDLE.
REQ-039 rst_ni low during WR_BUSY -> nor_ry_o=1 and mem_req_o=0 without clock edge; next read served normally.
REQ-040 Back-to-back write then read through the NOR bus initiator -> initiator waits on nor_ry_o, read returns written value.

Source files
------------

// File: rtl/nor_pkg.sv
// Shared NOR bus definitions, used by the NOR target and the NOR bus initiator.
//   nor_state_e          : target FSM state encoding
//   NorBusyCyclesDefault : default RY/BY low time after a write commit, in clocks
//   nor_state_busy()     : 1 for states in which RY/BY is driven low
package nor_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRdReq   = 3'd1,
    StRdDrive = 3'd2,
    StWrReq   = 3'd3,
    StWrBusy  = 3'd4,
    StRelease = 3'd5
  } nor_state_e;

  localparam logic [7:0] NorBusyCyclesDefault = 8'd5;

  function automatic logic nor_state_busy(nor_state_e s);
    return (s == StWrReq) || (s == StWrBusy);
  endfunction

endpackage

// File: rtl/nor_sync2.sv
// Two-flop synchronizer bank for the active-low NOR strobes.
// Flops reset to 1 so that a reset reads as "all strobes deasserted".
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d      : asynchronous inputs
//   q      : synchronized outputs (2 clocks of latency)
module nor_sync2 #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nor_target.sv
// NOR flash target: decodes asynchronous NOR strobes into single requests on a
// backing-store port, drives read data back and signals write busy on RY/BY.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   nor_ce_i/we_i/oe_i    : active-low NOR strobes (asynchronous to clk_i)
//   nor_addr_i, nor_data_i: NOR address and write data
//   nor_data_o, nor_data_oe: read data and its bus-drive enable
//   nor_ry_o              : 1 = ready, 0 = busy
//   mem_*                 : backing-store request/ack port
//   proto_err_o           : one-cycle pulse on ce=we=oe=0
module nor_target
  import nor_pkg::*;
#(
  parameter int unsigned ADDRBITS    = 26,
  parameter int unsigned DATABITS    = 16,
  parameter logic [7:0]  BUSY_CYCLES = NorBusyCyclesDefault
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                nor_ce_i,
  input  logic                nor_we_i,
  input  logic                nor_oe_i,
  input  logic [ADDRBITS-1:0] nor_addr_i,
  input  logic [DATABITS-1:0] nor_data_i,
  output logic [DATABITS-1:0] nor_data_o,
  output logic                nor_data_oe,
  output logic                nor_ry_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDRBITS-1:0] mem_addr_o,
  output logic [DATABITS-1:0] mem_data_o,
  input  logic [DATABITS-1:0] mem_data_i,
  input  logic                mem_ack_i,
  output logic                proto_err_o
);

  logic [2:0] strobe_s;
  logic       ce_s, we_s, oe_s;

  nor_sync2 #(
    .WIDTH (3)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d      ({nor_ce_i, nor_we_i, nor_oe_i}),
    .q      (strobe_s)
  );

  assign ce_s = strobe_s[2];
  assign we_s = strobe_s[1];
  assign oe_s = strobe_s[0];

  nor_state_e          state_q, state_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] wdata_q, wdata_d;
  logic [DATABITS-1:0] rdata_q, rdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                abort_q, abort_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        // Address/data pins are sampled once the strobes have crossed the
        // synchronizer, so they have been stable for at least two clocks.
        if (!ce_s) begin
          if (!we_s && !oe_s) begin
            state_d = StRelease;
          end else if (!oe_s) begin
            addr_d  = nor_addr_i;
            state_d = StRdReq;
          end else if (!we_s) begin
            addr_d  = nor_addr_i;
            wdata_d = nor_data_i;
            state_d = StWrReq;
          end
        end
      end
      StRdReq: begin
        // Initiator gave up: finish the access but never drive the bus.
        if (ce_s) abort_d = 1'b1;
        if (mem_ack_i) begin
          rdata_d = mem_data_i;
          state_d = (abort_q || ce_s) ? StRelease : StRdDrive;
        end
      end
      StRdDrive: begin
        if (ce_s || oe_s) state_d = StIdle;
      end
      StWrReq: begin
        if (mem_ack_i) begin
          cnt_d   = '0;
          state_d = StWrBusy;
        end
      end
      StWrBusy: begin
        if (cnt_q == BUSY_CYCLES) state_d = StRelease;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      StRelease: begin
        if (ce_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_req_o   = (state_q == StRdReq) || (state_q == StWrReq);
  assign mem_we_o    = (state_q == StWrReq);
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;
  assign nor_data_o  = rdata_q;
  // Gated with we so a stray write strobe can never collide with our drive.
  assign nor_data_oe = (state_q == StRdDrive) && we_s;
  assign nor_ry_o    = !nor_state_busy(state_q);
  assign proto_err_o = (state_q == StIdle) && !ce_s && !we_s && !oe_s;

endmodule
